ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It is the opposite direction to ps2_kbd, which receives device-to-host frames. It shares the same ps2_clk/ps2_data lines and drives them only through open-drain pull-low enables.
- The top level ties the enables to tri-state pads. While tx_active is high, ps2_kbd input is gated off.

Parameters:
- INHIBIT_CYCLES, 20000: clk cycles ps2_clk is held low before the request (100 us at 200 MHz).
- SETUP_CYCLES, 200: clk cycles ps2_clk and ps2_data are both held low before ps2_clk is released.
- TIMEOUT_CYCLES, 3000000: maximum clk cycles from SEND entry to the ACK edge (15 ms at 200 MHz).

Ports:
- clk, input, 1: system clock (clk200m domain).
- clrn, input, 1: asynchronous active-low reset.
- tx_data, input, 8: command byte; sampled on the handshake.
- tx_valid, input, 1: request to send tx_data.
- tx_ready, output, 1: block can accept a byte (high only in IDLE).
- ps2_clk_in, input, 1: ps2_clk pad value (asynchronous).
- ps2_data_in, input, 1: ps2_data pad value (asynchronous).
- ps2_clk_drv_low, output, 1: 1 = pull ps2_clk low, 0 = release.
- ps2_data_drv_low, output, 1: 1 = pull ps2_data low, 0 = release.
- tx_active, output, 1: high in every state except IDLE; gates ps2_kbd.
- done, output, 1: one-cycle pulse when a transfer ends.
- err, output, 1: valid only with done; 1 = timeout or NACK.

Behaviour:
- **Reset (clrn=0), asynchronous at any time including mid-frame:**
  - state=IDLE.
  - tx_ready=1; both drv_low=0 (lines released immediately); tx_active=0; done=0; err=0.
  - All counters 0.
- **Input synchronisation:**
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser.
  - fall = previous synced clk is 1 and current synced clk is 0.
  - Pin-to-fall latency is 3 clk.
- **Handshake:**
  - Accept when tx_valid && tx_ready. Latch tx_data and compute odd parity, par = ~^tx_data.
  - Next cycle: state=INHIBIT, tx_ready=0.
  - tx_valid outside IDLE is ignored.
- **State machine (all outputs registered):**
  - IDLE: both lines released.
  - INHIBIT: clk_drv_low=1 for exactly INHIBIT_CYCLES cycles, then go to SETUP.
  - SETUP: clk_drv_low=1 and data_drv_low=1 for SETUP_CYCLES cycles. Then go to SEND with clk_drv_low=0 and data_drv_low=1 (start bit). Bit counter n=0; timeout counter cleared.
  - SEND, on each fall:
    - n=0..7: data_drv_low = ~tx_data[n] (LSB first).
    - n=8: data_drv_low = ~par.
    - n=9: data_drv_low = 0 (stop bit released); go to ACK.
    - n increments on each fall.
  - ACK, on the next fall: sample synced data. 0 means ACK (err_next=0); 1 means NACK (err_next=1). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk=1 and synced data=1 in the same cycle. Then pulse done with err=err_next, and go to IDLE.
- **Timeout:**
  - Counter runs in SEND and ACK.
  - When it reaches TIMEOUT_CYCLES-1 without completing ACK: release both lines, pulse done with err=1, go to IDLE. WAIT_IDLE is skipped.
  - Timeout has priority over a fall in the same cycle.
- **Done/ready timing:**
  - done and the IDLE entry occur in the same cycle; tx_ready=1 in that cycle.
  - A tx_valid in that cycle is accepted, so back-to-back commands are allowed.
- **Widths:**
  - Counters are sized with $clog2 of the respective parameter.
  - n is 4 bits.
  - No wrap: counters saturate or clear on state exit.
- **Edge handling:**
  - Falls during INHIBIT, SETUP or WAIT_IDLE are ignored.
  - In INHIBIT and SETUP, a device-driven ps2_clk is overridden by the host holding ps2_clk low.

Test Plan (sim parameters INHIBIT_CYCLES=8, SETUP_CYCLES=2, TIMEOUT_CYCLES=1000; device model generates ps2_clk with 40-clk period):
- Send 0xED, device ACKs:
  - Required: clk_drv_low high exactly 10 cycles (8 inhibit + 2 setup).
  - Data sampled by the device on rising edges = 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Then done=1, err=0, tx_ready=1 in the same cycle.
- Send 0x01 and 0xFF back-to-back (tx_valid held): parity bits 0 and 1; exactly two done pulses with err=0; second INHIBIT starts the cycle after the first done.
- Device holds data high on the 11th edge (NACK) for 0x00: done=1, err=1; both drv_low=0 afterwards.
- Device never clocks after SETUP: done=1 and err=1 exactly 1000 cycles after SEND entry; both lines released.
- Pulse clrn low after the 4th falling edge of a 0xED transfer: within the reset cycle both drv_low=0, tx_active=0, tx_ready=1. After release, a new 0xF4 transfer completes with err=0.
- tx_valid pulsed during SEND: no effect; the frame bits still match the first byte, and only one done pulse occurs.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, ACK sample, with a timeout from SEND entry to ACK.
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   tx_data, tx_valid         command byte and request (accepted in IDLE)
//   tx_ready                  high only in IDLE
//   ps2_clk_in, ps2_data_in   asynchronous pad values
//   ps2_clk_drv_low           1 = pull ps2_clk low
//   ps2_data_drv_low          1 = pull ps2_data low
//   tx_active                 high outside IDLE (gates the receiver)
//   done, err                 one-cycle end pulse; err = timeout or NACK
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 20000,
    parameter int SETUP_CYCLES   = 200,
    parameter int TIMEOUT_CYCLES = 3000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drv_low,
    output logic       ps2_data_drv_low,
    output logic       tx_active,
    output logic       done,
    output logic       err
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [SW-1:0] SU_LAST  = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SETUP,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_n;
    logic [IW-1:0] inh_q, inh_n;
    logic [SW-1:0] su_q, su_n;
    logic [TW-1:0] to_q, to_n;
    logic [3:0]    bit_q, bit_n;
    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic          nack_q, nack_n;
    logic          clk_drv_q, clk_drv_n;
    logic          data_drv_q, data_drv_n;
    logic          done_q, done_n;
    logic          err_q, err_n;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    // Synchronisers idle high so reset release never looks like a fall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data_in;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            inh_q      <= '0;
            su_q       <= '0;
            to_q       <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            nack_q     <= 1'b0;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            inh_q      <= inh_n;
            su_q       <= su_n;
            to_q       <= to_n;
            bit_q      <= bit_n;
            data_q     <= data_n;
            par_q      <= par_n;
            nack_q     <= nack_n;
            clk_drv_q  <= clk_drv_n;
            data_drv_q <= data_drv_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        inh_n      = '0;
        su_n       = '0;
        to_n       = '0;
        bit_n      = '0;
        data_n     = data_q;
        par_n      = par_q;
        nack_n     = nack_q;
        clk_drv_n  = clk_drv_q;
        data_drv_n = data_drv_q;
        done_n     = 1'b0;
        err_n      = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_drv_n  = 1'b0;
                data_drv_n = 1'b0;
                if (tx_valid) begin
                    data_n    = tx_data;
                    par_n     = ~^tx_data;
                    clk_drv_n = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_drv_n = 1'b1;
                if (inh_q == INH_LAST) begin
                    data_drv_n = 1'b1;
                    state_n    = SETUP;
                end else begin
                    inh_n = inh_q + 1'b1;
                end
            end
            SETUP: begin
                if (su_q == SU_LAST) begin
                    // Releasing ps2_clk with data low is the start bit.
                    clk_drv_n  = 1'b0;
                    data_drv_n = 1'b1;
                    state_n    = SEND;
                end else begin
                    su_n = su_q + 1'b1;
                end
            end
            SEND: begin
                bit_n = bit_q;
                if (to_q == TO_LAST) begin
                    clk_drv_n  = 1'b0;
                    data_drv_n = 1'b0;
                    done_n     = 1'b1;
                    err_n      = 1'b1;
                    state_n    = IDLE;
                end else begin
                    to_n = to_q + 1'b1;
                    if (fall) begin
                        bit_n = bit_q + 1'b1;
                        unique case (1'b1)
                            (bit_q < 4'd8):
                                data_drv_n = ~data_q[bit_q[2:0]];
                            (bit_q == 4'd8):
                                data_drv_n = ~par_q;
                            default: begin
                                data_drv_n = 1'b0;
                                state_n    = ACK;
                            end
                        endcase
                    end
                end
            end
            ACK: begin
                if (to_q == TO_LAST) begin
                    clk_drv_n  = 1'b0;
                    data_drv_n = 1'b0;
                    done_n     = 1'b1;
                    err_n      = 1'b1;
                    state_n    = IDLE;
                end else begin
                    to_n = to_q + 1'b1;
                    if (fall) begin
                        nack_n  = dat_s2;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    done_n  = 1'b1;
                    err_n   = nack_q;
                    state_n = IDLE;
                end
            end
            default: begin
                clk_drv_n  = 1'b0;
                data_drv_n = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    assign tx_ready         = (state_q == IDLE);
    assign tx_active        = (state_q != IDLE);
    assign ps2_clk_drv_low  = clk_drv_q;
    assign ps2_data_drv_low = data_drv_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule
